// File: rtl/move_zero_sequencer.sv
// Job scheduler in front of a single MoveZero engine.
// Queues move jobs, issues them one at a time and commits each result board.
module move_zero_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic [63:0] i_klotski,
   input  logic        i_job_valid,
   output logic        o_job_ready,
   input  logic [3:0]  i_job_target,
   input  logic [15:0] i_job_mask,
   input  logic        i_job_flag,
   output logic        o_mz_start,
   output logic        o_mz_flag,
   output logic [63:0] o_mz_klotski,
   output logic [15:0] o_mz_mask,
   output logic [3:0]  o_mz_target,
   input  logic [63:0] i_mz_klotski,
   input  logic        i_mz_finished,
   input  logic        i_clear,
   output logic [63:0] o_klotski,
   output logic        o_board_valid,
   output logic        o_busy,
   output logic        o_job_done,
   output logic        o_job_skip,
   output logic [7:0]  o_done_cnt,
   output logic        o_error
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

   typedef struct packed {
      logic [3:0]  target;
      logic [15:0] mask;
      logic        flag;
   } job_t;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WAIT,
      ERROR
   } state_t;

   state_t        state;
   job_t          fifo_q [FIFO_DEPTH];
   job_t          head;
   job_t          new_job;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          tgt_masked;
   logic          zero_at_tgt;
   logic [63:0]   board_q;
   logic [7:0]    tmo_cnt;

   assign full        = count == (AW+1)'(FIFO_DEPTH);
   assign empty       = count == '0;
   assign push        = i_job_valid && !full;
   assign head        = fifo_q[rd_ptr];
   assign new_job     = '{target: i_job_target, mask: i_job_mask, flag: i_job_flag};
   assign tgt_masked  = head.mask[head.target];
   assign zero_at_tgt = board_q[{head.target, 2'b00} +: 4] == 4'd0;

   always_comb begin
      pop = 1'b0;
      if (state == CHECK)
         pop = tgt_masked || zero_at_tgt;
      else if (state == WAIT)
         pop = i_mz_finished;
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (push)
         fifo_q[wr_ptr] <= new_job;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW+1)'(1);
         else if (pop && !push)
            count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         board_q       <= '0;
         o_board_valid <= 1'b0;
         o_mz_start    <= 1'b0;
         o_mz_flag     <= 1'b0;
         o_mz_mask     <= '0;
         o_mz_target   <= '0;
         o_job_done    <= 1'b0;
         o_job_skip    <= 1'b0;
         o_done_cnt    <= '0;
         o_error       <= 1'b0;
         tmo_cnt       <= '0;
      end else begin
         o_mz_start <= 1'b0;
         o_job_done <= 1'b0;
         o_job_skip <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_load && empty) begin
                  board_q       <= i_klotski;
                  o_board_valid <= 1'b1;
               end
               if (!empty && o_board_valid)
                  state <= CHECK;
            end
            CHECK: begin
               if (tgt_masked) begin
                  o_job_done <= 1'b1;
                  o_job_skip <= 1'b1;
                  o_done_cnt <= o_done_cnt + 8'd1;
                  state      <= IDLE;
               end else if (zero_at_tgt) begin
                  o_job_done <= 1'b1;
                  o_done_cnt <= o_done_cnt + 8'd1;
                  state      <= IDLE;
               end else begin
                  o_mz_target <= head.target;
                  o_mz_mask   <= head.mask;
                  o_mz_flag   <= head.flag;
                  o_mz_start  <= 1'b1;
                  tmo_cnt     <= '0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               // finished takes priority over an expiring timeout
               if (i_mz_finished) begin
                  board_q    <= i_mz_klotski;
                  o_job_done <= 1'b1;
                  o_done_cnt <= o_done_cnt + 8'd1;
                  state      <= IDLE;
               end else if (tmo_cnt == TMO_MAX) begin
                  o_error <= 1'b1;
                  state   <= ERROR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            ERROR: begin
               if (i_clear) begin
                  o_error <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_job_ready  = !full;
   assign o_busy       = (state != IDLE) || !empty;
   assign o_klotski    = board_q;
   assign o_mz_klotski = board_q;

endmodule

// File: tb/tb_move_zero_sequencer.sv
// Scoreboard bench for move_zero_sequencer with a behavioural MoveZero stub.
// Expected retire order, skip flags and boards are predicted when jobs are pushed.
module tb_move_zero_sequencer;

   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [63:0] klotski = '0;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [3:0]  job_target = '0;
   logic [15:0] job_mask = '0;
   logic        job_flag = 1'b0;
   logic        mz_start;
   logic        mz_flag;
   logic [63:0] mz_klotski_o;
   logic [15:0] mz_mask;
   logic [3:0]  mz_target;
   logic [63:0] mz_kl = '0;
   logic        mz_fin = 1'b0;
   logic        clear = 1'b0;
   logic [63:0] board;
   logic        board_valid;
   logic        busy;
   logic        job_done;
   logic        job_skip;
   logic [7:0]  done_cnt;
   logic        error;

   always #5 clk = ~clk;

   move_zero_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(rst), .i_load(load), .i_klotski(klotski),
      .i_job_valid(job_valid), .o_job_ready(job_ready),
      .i_job_target(job_target), .i_job_mask(job_mask), .i_job_flag(job_flag),
      .o_mz_start(mz_start), .o_mz_flag(mz_flag), .o_mz_klotski(mz_klotski_o),
      .o_mz_mask(mz_mask), .o_mz_target(mz_target),
      .i_mz_klotski(mz_kl), .i_mz_finished(mz_fin), .i_clear(clear),
      .o_klotski(board), .o_board_valid(board_valid), .o_busy(busy),
      .o_job_done(job_done), .o_job_skip(job_skip),
      .o_done_cnt(done_cnt), .o_error(error)
   );

   typedef struct {
      logic        skip;
      logic        run;
      logic [3:0]  target;
      logic [15:0] mask;
      logic        flag;
      logic [63:0] pre;
      logic [63:0] board;
   } exp_t;

   exp_t        sb[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          starts = 0;
   int          dones = 0;
   logic [63:0] model_board = '0;
   bit          stub_en = 1'b1;
   int          stub_lat = 3;

   // Slide the single zero tile onto the target cell.
   function automatic logic [63:0] mz_model(input logic [63:0] b, input logic [3:0] t);
      logic [63:0] r;
      int z;
      r = b;
      z = 0;
      for (int i = 0; i < 16; i++)
         if (b[i*4 +: 4] == 4'd0) z = i;
      r[z*4 +: 4] = b[int'(t)*4 +: 4];
      r[int'(t)*4 +: 4] = 4'd0;
      return r;
   endfunction

   function automatic int zero_pos(input logic [63:0] b);
      int z;
      z = 0;
      for (int i = 0; i < 16; i++)
         if (b[i*4 +: 4] == 4'd0) z = i;
      return z;
   endfunction

   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (mz_start) begin
         starts++;
         n_total++;
         if (sb.size() == 0 || !sb[0].run)
            $display("FAIL mz_start_unexpected: start=1 required none (queued=%0d)", sb.size());
         else if ({mz_target, mz_mask, mz_flag, mz_klotski_o} !==
                  {sb[0].target, sb[0].mask, sb[0].flag, sb[0].pre})
            $display("FAIL mz_issue: got t=%h m=%h f=%b b=%h required t=%h m=%h f=%b b=%h",
                     mz_target, mz_mask, mz_flag, mz_klotski_o,
                     sb[0].target, sb[0].mask, sb[0].flag, sb[0].pre);
         else
            n_pass++;
      end
      if (job_done) begin
         dones++;
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL job_done_unexpected: done=1 required none");
         end else begin
            e = sb.pop_front();
            if (job_skip !== e.skip || board !== e.board)
               $display("FAIL job_retire: skip=%b board=%h required skip=%b board=%h",
                        job_skip, board, e.skip, e.board);
            else
               n_pass++;
         end
      end
   end

   always begin : stub
      logic [63:0] res;
      @(posedge clk);
      #1;
      if (mz_start && stub_en) begin
         res = mz_model(mz_klotski_o, mz_target);
         repeat (stub_lat) @(negedge clk);
         mz_kl  = res;
         mz_fin = 1'b1;
         @(negedge clk);
         mz_fin = 1'b0;
      end
   end

   task automatic push_job(input logic [3:0] t, input logic [15:0] m, input logic f,
                           output int waited);
      exp_t e;
      @(negedge clk);
      job_valid  = 1'b1;
      job_target = t;
      job_mask   = m;
      job_flag   = f;
      waited     = 0;
      while (!job_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!job_ready) begin
         n_total++;
         $display("FAIL push_accept: ready=0 after %0d cycles required 1", waited);
         job_valid = 1'b0;
         return;
      end
      @(posedge clk);
      e.skip   = m[t];
      e.target = t;
      e.mask   = m;
      e.flag   = f;
      e.pre    = model_board;
      e.run    = !e.skip && (model_board[int'(t)*4 +: 4] != 4'd0);
      if (e.run)
         model_board = mz_model(model_board, t);
      e.board = model_board;
      sb.push_back(e);
   endtask

   task automatic end_push();
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic drain(output bit ok);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while ((sb.size() != 0 || busy) && c < 600);
      ok = (sb.size() == 0) && !busy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      sb.delete();
      model_board = '0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if ({mz_start, job_done, job_skip, error, busy, board_valid, mz_flag} !== 7'd0)
         $display("FAIL reset_flags: %b required 0000000",
                  {mz_start, job_done, job_skip, error, busy, board_valid, mz_flag});
      else n_pass++;
      n_total++;
      if (done_cnt !== 8'd0 || board !== 64'd0)
         $display("FAIL reset_board_cnt: cnt=%0d board=%h required 0 and 0", done_cnt, board);
      else n_pass++;
      n_total++;
      if ({mz_klotski_o, mz_mask, mz_target} !== 84'd0)
         $display("FAIL reset_mz_bus: %h required 0", {mz_klotski_o, mz_mask, mz_target});
      else n_pass++;
      n_total++;
      if (job_ready !== 1'b1)
         $display("FAIL reset_ready: ready=%b required 1", job_ready);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_single_job();
      int vals [16] = '{10, 1, 14, 12, 6, 2, 9, 15, 3, 7, 5, 4, 0, 11, 8, 13};
      logic [63:0] b0;
      int s0, w;
      bit ok;
      for (int i = 0; i < 16; i++) b0[i*4 +: 4] = 4'(vals[i]);
      @(negedge clk);
      load = 1'b1;
      klotski = b0;
      @(negedge clk);
      load = 1'b0;
      model_board = b0;
      n_total++;
      if (board_valid !== 1'b1 || board !== b0)
         $display("FAIL load: valid=%b board=%h required 1 %h", board_valid, board, b0);
      else n_pass++;
      s0 = starts;
      push_job(4'd0, 16'h0120, 1'b1, w);
      @(negedge clk);
      job_valid = 1'b0;
      @(posedge clk);
      #2;
      n_total++;
      if (mz_start !== 1'b0)
         $display("FAIL latency_early: start=%b required 0 one cycle after push", mz_start);
      else n_pass++;
      @(posedge clk);
      #2;
      n_total++;
      if (mz_start !== 1'b1)
         $display("FAIL latency_start: start=%b required 1 two cycles after push", mz_start);
      else n_pass++;
      drain(ok);
      n_total++;
      if (!ok || starts - s0 != 1 || done_cnt !== 8'd1 || board !== model_board)
         $display("FAIL single_job: drained=%b starts=%0d cnt=%0d board=%h required 1 1 1 %h",
                  ok, starts - s0, done_cnt, board, model_board);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] cnt0;
      int w;
      bit ok;
      cnt0 = done_cnt;
      stub_lat = 8;
      push_job(4'd5, 16'h0, 1'b0, w);
      push_job(4'd10, 16'h0, 1'b1, w);
      push_job(4'd15, 16'h0, 1'b0, w);
      push_job(4'd6, 16'h0, 1'b1, w);
      #2;
      n_total++;
      if (job_ready !== 1'b0)
         $display("FAIL full_ready: ready=%b required 0 after 4 pushes", job_ready);
      else n_pass++;
      push_job(4'd0, 16'h0, 1'b0, w);
      n_total++;
      if (w == 0)
         $display("FAIL fifth_held: waited=%0d required >0", w);
      else n_pass++;
      @(negedge clk);
      job_valid = 1'b0;
      load = 1'b1;
      klotski = '1;
      @(negedge clk);
      load = 1'b0;
      drain(ok);
      n_total++;
      if (!ok || done_cnt !== cnt0 + 8'd5 || board !== model_board)
         $display("FAIL back_to_back: drained=%b cnt=%0d board=%h required 1 %0d %h",
                  ok, done_cnt, board, cnt0 + 8'd5, model_board);
      else n_pass++;
      stub_lat = 3;
   endtask

   task automatic test_skip();
      logic [7:0] cnt0;
      logic [63:0] b0;
      int s0, w;
      bit ok;
      cnt0 = done_cnt;
      b0 = board;
      s0 = starts;
      push_job(4'd3, 16'h0008, 1'b0, w);
      end_push();
      drain(ok);
      n_total++;
      if (!ok || starts != s0 || done_cnt !== cnt0 + 8'd1 || board !== b0)
         $display("FAIL skip_masked: drained=%b starts=%0d cnt=%0d board=%h required 1 0 %0d %h",
                  ok, starts - s0, done_cnt, board, cnt0 + 8'd1, b0);
      else n_pass++;
   endtask

   task automatic test_zero_at_target();
      logic [7:0] cnt0;
      int s0, w;
      bit ok;
      cnt0 = done_cnt;
      s0 = starts;
      push_job(4'(zero_pos(model_board)), 16'h0, 1'b1, w);
      end_push();
      drain(ok);
      n_total++;
      if (!ok || starts != s0 || done_cnt !== cnt0 + 8'd1)
         $display("FAIL zero_at_target: drained=%b starts=%0d cnt=%0d required 1 0 %0d",
                  ok, starts - s0, done_cnt, cnt0 + 8'd1);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [7:0] cnt0;
      int s0, d0, w, c, z;
      bit ok;
      stub_en = 1'b0;
      cnt0 = done_cnt;
      s0 = starts;
      z = zero_pos(model_board);
      push_job(4'((z + 1) % 16), 16'h0, 1'b0, w);
      end_push();
      c = 0;
      while (starts == s0 && c < 20) begin
         @(negedge clk);
         c++;
      end
      c = 0;
      while (!error && c < 400) begin
         @(negedge clk);
         c++;
      end
      n_total++;
      if (error !== 1'b1 || c < TIMEOUT - 4 || c > TIMEOUT + 4)
         $display("FAIL timeout_error: error=%b after %0d cycles required 1 near %0d",
                  error, c, TIMEOUT);
      else n_pass++;
      d0 = dones;
      push_job(4'd9, 16'h0200, 1'b0, w);
      end_push();
      repeat (4) @(negedge clk);
      n_total++;
      if (w != 0 || dones != d0 || error !== 1'b1 || busy !== 1'b1)
         $display("FAIL error_hold: wait=%0d dones=%0d err=%b busy=%b required 0 0 1 1",
                  w, dones - d0, error, busy);
      else n_pass++;
      stub_en = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_total++;
      if (error !== 1'b0)
         $display("FAIL clear_error: error=%b required 0", error);
      else n_pass++;
      drain(ok);
      n_total++;
      if (!ok || starts - s0 != 2 || done_cnt !== cnt0 + 8'd2)
         $display("FAIL reissue: drained=%b starts=%0d cnt=%0d required 1 2 %0d",
                  ok, starts - s0, done_cnt, cnt0 + 8'd2);
      else n_pass++;
   endtask

   task automatic test_reset_in_wait();
      int s0, d0, w, c, z;
      stub_en = 1'b0;
      s0 = starts;
      z = zero_pos(model_board);
      push_job(4'((z + 4) % 16), 16'h0, 1'b1, w);
      end_push();
      c = 0;
      while (starts == s0 && c < 20) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      model_board = '0;
      n_total++;
      if ({mz_start, job_done, job_skip, error, busy, board_valid} !== 6'd0 ||
          done_cnt !== 8'd0 || board !== 64'd0 || job_ready !== 1'b1)
         $display("FAIL reset_in_wait: flags=%b cnt=%0d board=%h ready=%b required 0 0 0 1",
                  {mz_start, job_done, job_skip, error, busy, board_valid},
                  done_cnt, board, job_ready);
      else n_pass++;
      d0 = dones;
      mz_kl = 64'h0123_4567_89ab_cdef;
      mz_fin = 1'b1;
      repeat (2) @(negedge clk);
      mz_fin = 1'b0;
      @(negedge clk);
      n_total++;
      if (board !== 64'd0 || dones != d0 || done_cnt !== 8'd0)
         $display("FAIL late_finished: board=%h dones=%0d cnt=%0d required 0 0 0",
                  board, dones - d0, done_cnt);
      else n_pass++;
      s0 = starts;
      push_job(4'd1, 16'h0, 1'b0, w);
      end_push();
      repeat (10) @(negedge clk);
      n_total++;
      if (starts != s0 || dones != d0 || busy !== 1'b1)
         $display("FAIL no_board_hold: starts=%0d dones=%0d busy=%b required 0 0 1",
                  starts - s0, dones - d0, busy);
      else n_pass++;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_back_to_back();
      test_skip();
      test_zero_at_target();
      test_timeout();
      test_reset_in_wait();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
